// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and FSM encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord       = '0;
  localparam logic [InstBus-1:0]     NopInst        = 32'h0000_0000;
  localparam logic [InstAddrBus-1:0] ResetPcDefault = 32'h0000_0000;
  localparam int unsigned            QdepthDefault  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage and memory.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   mem_req_o;
  logic [InstAddrBus-1:0] mem_addr_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [InstBus-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/if_fifo.sv
// In-order instruction queue; flush wins over push and pop.
module if_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [Width-1:0]       din_i,
  output logic [Width-1:0]       dout_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = din_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop_i) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // The fetch credit rule must make this unreachable.
      assert (flush_i || !(push_i && !pop_i && count_q == FullCnt));
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding memory fetch, queue to ID.
// IF_MISALIGN_CHK_EN adds if_misalign_o and blocks fetching after a misaligned redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ResetPcDefault,
  parameter int unsigned            QDEPTH   = QdepthDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  if_fetch_if.master             mem,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic                   if_misalign_o
`endif
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;
  localparam logic [CntW-1:0] QdepthCnt = CntW'(QDEPTH);

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
  logic [InstAddrBus-1:0] req_pc_q, req_pc_d;
  logic                   discard_q, discard_d;

  logic                   fetch_block;
  logic [InstAddrBus-1:0] target_eff;
  logic                   mem_req;
  logic                   granted;
  logic                   push, pop;
  logic [CntW-1:0]        count;
  logic                   empty;
  logic [InstAddrBus+InstBus-1:0] head;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (branch_flag_i) begin
      misalign_d = |branch_target_i[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_block   = misalign_q;
  assign target_eff    = branch_target_i;
  assign if_misalign_o = misalign_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target_i[1:0];
  assign fetch_block    = 1'b0;
  assign target_eff     = {branch_target_i[InstAddrBus-1:2], 2'b00};
`endif

  // Nothing is outstanding in REQ, so the credit check reduces to queue occupancy.
  assign mem_req        = (state_q == StReq) && !fetch_block && (count < QdepthCnt);
  assign granted        = mem_req && mem.mem_gnt_i;
  assign mem.mem_req_o  = mem_req;
  assign mem.mem_addr_o = mem_req ? fetch_pc_q : ZeroWord;

  assign push = (state_q == StWait) && mem.mem_rvalid_i && !discard_q && !branch_flag_i;
  assign pop  = !empty && !stall_i && !branch_flag_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (granted) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (mem.mem_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    if (branch_flag_i) begin
      fetch_pc_d = target_eff;
      // A response still in flight belongs to the old path and must be swallowed.
      if (!discard_q && (granted || (state_q == StWait && !mem.mem_rvalid_i))) begin
        discard_d = 1'b1;
        state_d   = StWait;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  if_fifo #(
    .Depth(QDEPTH),
    .Width(InstAddrBus + InstBus)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(branch_flag_i),
    .din_i  ({req_pc_q, mem.mem_rdata_i}),
    .dout_o (head),
    .count_o(count),
    .empty_o(empty)
  );

  assign if_valid_o = !empty;
  assign if_pc_o    = empty ? ZeroWord : head[InstAddrBus+InstBus-1:InstBus];
  assign if_inst_o  = empty ? NopInst : head[InstBus-1:0];

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch with a req/gnt/rvalid memory model of variable latency.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  if_fetch_if mem ();

  if_fetch #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_flag_i  (br),
    .branch_target_i(tgt),
    .mem            (mem),
    .if_valid_o     (if_valid),
    .if_pc_o        (if_pc),
    .if_inst_o      (if_inst)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .if_misalign_o  (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [63:0] sb [$];
  logic        pend;
  logic        pend_stale;
  logic [31:0] pend_addr;
  int          wait_cnt;
  int          rv_lat;
  logic        gnt_en;
  logic [31:0] exp_addr;
  int          cyc;
  int          first_valid_cyc;
  int          n_gnt;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  function automatic logic [31:0] tgt_model(input logic [31:0] t);
`ifdef IF_MISALIGN_CHK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock: sample at negedge, drive inputs, update the model at the rising edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
    logic        rv;
    logic        g;
    logic [31:0] a;
    logic [63:0] e;
    @(negedge clk);
    check_val("if_valid", if_valid, sb.size() != 0);
    if (sb.size() == 0) begin
      check_val("empty_out", {if_pc, if_inst}, 64'h0);
    end else if (if_valid && !s && !b && !r) begin
      e = sb.pop_front();
      check_val("pop", {if_pc, if_inst}, e);
    end
    if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    rv = pend && (wait_cnt == 0);
    if (pend && wait_cnt != 0) wait_cnt--;
    g = mem.mem_req_o && gnt_en && !pend && !r;
    a = mem.mem_addr_o;
    if (g) check_val("fetch_addr", a, exp_addr);
    stall            = s;
    br               = b;
    tgt              = t;
    rst              = r;
    mem.mem_gnt_i    = g;
    mem.mem_rvalid_i = rv;
    mem.mem_rdata_i  = rv ? word_of(pend_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    cyc++;
    if (rv) begin
      if (!pend_stale && !b && !r) sb.push_back({pend_addr, word_of(pend_addr)});
      pend = 1'b0;
    end
    if (b || r) begin
      sb.delete();
      pend_stale = 1'b1;
    end
    if (g) begin
      n_gnt++;
      pend       = 1'b1;
      pend_stale = b;
      pend_addr  = a;
      wait_cnt   = rv_lat - 1;
      exp_addr   = a + 32'd4;
    end
    if (b) exp_addr = tgt_model(t);
    if (r) exp_addr = 32'h0;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run_until_req(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem.mem_req_o) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check_val(tag, found, 1'b1);
  endtask

  task automatic run_until_pend(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pend) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check_val(tag, found, 1'b1);
  endtask

  initial begin
    logic        found;
    logic [31:0] a0;
    n_vec = 0; n_err = 0;
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    mem.mem_gnt_i = 1'b0; mem.mem_rvalid_i = 1'b0; mem.mem_rdata_i = 32'h0;
    pend = 1'b0; pend_stale = 1'b0; pend_addr = 32'h0; wait_cnt = 0;
    rv_lat = 1; gnt_en = 1'b1; exp_addr = 32'h0; n_gnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req", mem.mem_req_o, 1'b0);
    check_val("rst_addr", mem.mem_addr_o, 32'h0);
    check_val("rst_if", {if_valid, if_pc, if_inst}, 65'h0);
`ifdef IF_MISALIGN_CHK_EN
    check_val("rst_misalign", if_misalign, 1'b0);
`endif
    cyc = 0;
    first_valid_cyc = -1;

    // Streaming from reset: 0,4,8,C,... at one word per two cycles.
    run(10);
    check_val("first_valid_cyc", first_valid_cyc, 3);
    check_val("throughput_gnts", n_gnt, 5);

    // Stall long enough to fill the queue and starve the credit.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (sb.size() != 0) check_val("stall_hold", if_pc, sb[0][63:32]);
    end
    check_val("stall_req_off", mem.mem_req_o, 1'b0);
    check_val("stall_valid", if_valid, 1'b1);
    run(8);

    // Redirect while waiting; the stale word arrives two cycles later.
    rv_lat = 3;
    run_until_pend("to_wait_a");
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    rv_lat = 1;
    run_until_req("to_req_a");
    check_val("redir_wait_addr", mem.mem_addr_o, 32'h0000_0100);
    run(6);

    // Redirect in the same cycle as a grant and a would-be pop.
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem.mem_req_o && if_valid) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check_val("to_req_valid", found, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    check_val("flush_empty", if_valid, 1'b0);
    check_val("discard_wait_req", mem.mem_req_o, 1'b0);
    run(6);

    // Request held without grant, then redirected.
    gnt_en = 1'b0;
    run_until_req("to_req_b");
    a0 = mem.mem_addr_o;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_val("hold_addr", {mem.mem_req_o, mem.mem_addr_o}, {1'b1, a0});
    step(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    check_val("redir_req_addr", {mem.mem_req_o, mem.mem_addr_o}, {1'b1, 32'h0000_0300});
    gnt_en = 1'b1;
    run(4);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pend && pend_addr == 32'hFFFF_FFFC) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check_val("to_wrap", found, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    run_until_req("to_req_c");
    check_val("wrap_addr", mem.mem_addr_o, 32'h0);
    run(6);

    // Reset pulse while a fetch is outstanding; its response lands after reset.
    rv_lat = 2;
    run_until_pend("to_wait_b");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    rv_lat = 1;
    check_val("mid_rst_mem", {mem.mem_req_o, mem.mem_addr_o}, 33'h0);
    check_val("mid_rst_if", {if_valid, if_pc, if_inst}, 65'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    run_until_req("to_req_d");
    check_val("restart_pc", mem.mem_addr_o, 32'h0);
    run(6);

`ifdef IF_MISALIGN_CHK_EN
    step(1'b0, 1'b1, 32'h0000_0102, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_val("misalign_flag", if_misalign, 1'b1);
      check_val("misalign_req", mem.mem_req_o, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    check_val("misalign_clear", if_misalign, 1'b0);
    run_until_req("to_req_e");
    check_val("realign_addr", mem.mem_addr_o, 32'h0000_0200);
`else
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    run_until_req("to_req_e");
    check_val("align_force", mem.mem_addr_o, 32'h0000_0100);
`endif
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the PC register and issues word fetches to instruction memory over a req/gnt/rvalid handshake, at most one outstanding.
- Buffers returned words in a small in-order queue and presents {pc, inst, valid} to ID.
- Honours the pipeline stall from downstream and PC redirects from the branch unit, discarding stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  ID/ctrl stall; head entry held
- branch_flag_i  in  1  redirect request, single-cycle pulse
- branch_target_i  in  32  redirect PC
- mem_req_o  out  1  fetch request valid
- mem_addr_o  out  32  fetch byte address, word aligned
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  response data valid
- mem_rdata_i  in  32  response instruction word
- if_valid_o  out  1  head entry valid to ID
- if_pc_o  out  32  head entry PC
- if_inst_o  out  32  head entry instruction

Behaviour:
- Reset: fetch_pc=RESET_PC, state IDLE, queue empty, discard=0.
- Reset values of outputs: mem_req_o=0, mem_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
- rst mid-transaction: the outstanding response is never pushed; a late rvalid after reset is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ: unconditionally, first cycle after reset deasserts.
  - REQ: mem_req_o=1 only if count+outstanding<QDEPTH; mem_addr_o=fetch_pc.
  - REQ on gnt: latch req_pc=fetch_pc, fetch_pc+=4 (mod 2^32, wraps silently), go to WAIT.
  - WAIT: mem_req_o=0.
  - WAIT on rvalid: push {req_pc, rdata} unless discard; clear discard; go to REQ.
- Once asserted, mem_req_o and mem_addr_o are held stable until gnt. The only exception is a redirect: the address changes to the target on the next cycle.
- Throughput: with a gnt same-cycle / rvalid next-cycle memory, one instruction per 2 cycles.
- Latency: rvalid cycle N → if_valid_o=1 at N+1.
- Outputs: if_* reflect the queue head.
  - When the queue is empty: if_valid_o=0, if_pc_o=0, if_inst_o=32'h0 (NOP).
- Pop when if_valid_o && !stall_i && !branch_flag_i.
- Push and pop in the same cycle are allowed at any count. The credit rule guarantees no overflow; an overflow is an assertion failure.
- Redirect (branch_flag_i=1), priority over stall, push and pop:
  - Queue flushed next cycle; fetch_pc=branch_target_i.
  - In WAIT, or REQ with gnt in the same cycle: discard=1, enter/stay WAIT until the stale rvalid, then REQ.
  - In REQ without gnt: stays REQ with the new address.
  - A redirect while discard=1 only updates fetch_pc.
- Response is pushed on the same cycle as a redirect: dropped.
- mem_rvalid_i outside WAIT: ignored.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined: adds output if_misalign_o (1 bit, reset 0). A redirect with target[1:0]!=0 sets it high and suppresses all fetching (mem_req_o=0) until the next aligned redirect or reset.
- Undefined: the port is absent; target[1:0] is forced to 2'b00.

Decomposition:
- Shared package/define file:
  - InstAddrBus/InstBus widths.
  - ZeroWord.
  - NOP_INST=32'h0.
  - if_fetch FSM state encodings.
  - RESET_PC default.
- One sub-module: if_fifo (sync FIFO, QDEPTH×64 bits).
  - Ports: push, pop, flush, din, dout, count, empty.
  - Flush has priority over push and pop.

Test Plan:
- Reset release, memory gnt same-cycle / rvalid +1, words A0..A3 → mem_addr_o 0,4,8,C; if_pc_o 0,4,8,C with matching insts; if_valid_o first high 3 cycles after reset.
- stall_i held 6 cycles → queue fills to 2; mem_req_o drops after count+outstanding=2; if_pc_o stays constant. Release stall → in-order resumption, no loss or duplicate.
- Redirect to 0x100 while in WAIT, stale rvalid 2 cycles later → stale word never appears; next mem_addr_o=0x100; if_pc_o=0x100 next valid.
- Redirect coincident with gnt and with pop → granted fetch discarded, queue empty next cycle, no pop to ID.
- fetch_pc=0xFFFF_FFFC → next fetch address 0x0000_0000.
- rst pulse mid-WAIT → all outputs zero next cycle; fetch restarts at RESET_PC. With IF_MISALIGN_CHK_EN: redirect to 0x102 → if_misalign_o=1, mem_req_o=0 until redirect to 0x200.
